// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control sequencer.
// Gives the state encoding and the decoder instruction classes.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DISPATCH,
    S_OPF,
    S_ALU,
    S_MEMRD,
    S_MEMWR,
    S_WB,
    S_HALTED
  } seq_state_t;

  localparam logic [2:0] ITYPE_ALU   = 3'd1;
  localparam logic [2:0] ITYPE_IMMBR = 3'd2;
  localparam logic [2:0] ITYPE_MOV   = 3'd3;
  localparam logic [2:0] ITYPE_REGBR = 3'd4;
  localparam logic [2:0] ITYPE_ST    = 3'd5;
  localparam logic [2:0] ITYPE_LD    = 3'd6;

endpackage

// File: rtl/seq_retire_counter.sv
// Saturating retired-instruction counter with synchronous clear.
// The counter stays at all-ones once it gets there.
module seq_retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_count <= '0;
    else if (i_clr)                     r_count <= '0;
    else if (i_inc && (r_count != '1))  r_count <= r_count + CNT_W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the CPU datapath: one stage enable per cycle,
// with the stage path chosen by the decoded instruction class.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             init,
  input  logic             start,
  input  logic [2:0]       inst_type,
  input  logic             is_halt,
  output logic             fetch_unit_en,
  output logic             decoder_en,
  output logic             reg_r_en,
  output logic             alu_en,
  output logic             memory_r_en,
  output logic             memory_w_en,
  output logic             reg_w_en,
  output logic             branch,
  output logic             branchi,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] MEM_LOAD = 4'(MEM_LAT - 1);

  seq_state_t r_state, w_next;
  logic [2:0] r_itype;
  logic [3:0] r_mem_cnt;
  logic       w_inc, w_set_err, w_clr_err;
  logic       r_fetch, r_dec, r_regr, r_alu, r_memr, r_memw, r_regw;
  logic       r_branch, r_done, r_err;

  always_ff @(posedge clk or posedge init) begin
    if (init) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_inc     = 1'b0;
    w_set_err = 1'b0;
    case (r_state)
      S_IDLE:     if (start) w_next = S_FETCH;
      S_FETCH:    w_next = S_DECODE;
      S_DECODE:   w_next = S_DISPATCH;
      S_DISPATCH: begin
        case (inst_type)
          ITYPE_ALU, ITYPE_REGBR, ITYPE_ST, ITYPE_LD: w_next = S_OPF;
          ITYPE_IMMBR: begin
            w_next = is_halt ? S_HALTED : S_FETCH;
            w_inc  = 1'b1;
          end
          ITYPE_MOV:  w_next = S_WB;
          default: begin
            w_next    = S_HALTED;
            w_set_err = 1'b1;
          end
        endcase
      end
      S_OPF: begin
        case (r_itype)
          ITYPE_ALU: w_next = S_ALU;
          ITYPE_ST:  w_next = S_MEMWR;
          ITYPE_LD:  w_next = S_MEMRD;
          default: begin
            w_next = S_FETCH;
            w_inc  = 1'b1;
          end
        endcase
      end
      S_ALU:      w_next = S_WB;
      S_MEMRD:    if (r_mem_cnt == 4'd0) w_next = S_WB;
      S_MEMWR: begin
        if (r_mem_cnt == 4'd0) begin
          w_next = S_FETCH;
          w_inc  = 1'b1;
        end
      end
      S_WB: begin
        w_next = S_FETCH;
        w_inc  = 1'b1;
      end
      S_HALTED:   if (start) w_next = S_FETCH;
      default:    w_next = S_IDLE;
    endcase
  end

  assign w_clr_err = start && ((r_state == S_IDLE) || (r_state == S_HALTED));

  // Class is held past DISPATCH because OPF needs it to pick its successor.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_itype   <= 3'd0;
      r_mem_cnt <= 4'd0;
    end else begin
      if (r_state == S_DISPATCH) r_itype <= inst_type;
      if ((r_state == S_OPF) && ((w_next == S_MEMRD) || (w_next == S_MEMWR)))
        r_mem_cnt <= MEM_LOAD;
      else if (r_mem_cnt != 4'd0)
        r_mem_cnt <= r_mem_cnt - 4'd1;
    end
  end

  // Outputs are flops loaded from the next-state decode, so they track r_state glitch-free.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_fetch  <= 1'b0;
      r_dec    <= 1'b0;
      r_regr   <= 1'b0;
      r_alu    <= 1'b0;
      r_memr   <= 1'b0;
      r_memw   <= 1'b0;
      r_regw   <= 1'b0;
      r_branch <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_fetch  <= (w_next == S_FETCH);
      r_dec    <= (w_next == S_DECODE);
      r_regr   <= (w_next == S_OPF);
      r_alu    <= (w_next == S_ALU);
      r_memr   <= (w_next == S_MEMRD);
      r_memw   <= (w_next == S_MEMWR);
      r_regw   <= (w_next == S_WB);
      r_branch <= (r_state == S_DISPATCH) && (inst_type == ITYPE_REGBR);
      r_done   <= (w_next == S_HALTED);
      if (w_set_err)      r_err <= 1'b1;
      else if (w_clr_err) r_err <= 1'b0;
    end
  end

  seq_retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk     (clk),
    .rst     (init),
    .i_clr   ((r_state == S_IDLE) && start),
    .i_inc   (w_inc),
    .o_count (retired)
  );

  assign fetch_unit_en = r_fetch;
  assign decoder_en    = r_dec;
  assign reg_r_en      = r_regr;
  assign alu_en        = r_alu;
  assign memory_r_en   = r_memr;
  assign memory_w_en   = r_memw;
  assign reg_w_en      = r_regw;
  assign branch        = r_branch;
  // inst_type only becomes valid in DISPATCH, so the immediate-branch strobe decodes it directly.
  assign branchi       = (r_state == S_DISPATCH) && (inst_type == ITYPE_IMMBR) && !is_halt;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scoreboard bench for cpu_sequencer (MEM_LAT=3, CNT_W=4).
// Expected per-cycle output vectors are queued per instruction and popped at each negedge.
module tb_cpu_sequencer;

  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 4;

  localparam logic [10:0] F  = 11'h400;
  localparam logic [10:0] D  = 11'h200;
  localparam logic [10:0] N  = 11'h000;
  localparam logic [10:0] R  = 11'h100;
  localparam logic [10:0] A  = 11'h080;
  localparam logic [10:0] MR = 11'h040;
  localparam logic [10:0] MW = 11'h020;
  localparam logic [10:0] W  = 11'h010;
  localparam logic [10:0] B  = 11'h008;
  localparam logic [10:0] BI = 11'h004;
  localparam logic [10:0] DN = 11'h002;
  localparam logic [10:0] E  = 11'h001;

  logic             clk = 1'b0;
  logic             init, start, is_halt;
  logic [2:0]       inst_type;
  logic             fetch_unit_en, decoder_en, reg_r_en, alu_en;
  logic             memory_r_en, memory_w_en, reg_w_en;
  logic             branch, branchi, done, err;
  logic [CNT_W-1:0] retired;

  cpu_sequencer #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .init          (init),
    .start         (start),
    .inst_type     (inst_type),
    .is_halt       (is_halt),
    .fetch_unit_en (fetch_unit_en),
    .decoder_en    (decoder_en),
    .reg_r_en      (reg_r_en),
    .alu_en        (alu_en),
    .memory_r_en   (memory_r_en),
    .memory_w_en   (memory_w_en),
    .reg_w_en      (reg_w_en),
    .branch        (branch),
    .branchi       (branchi),
    .done          (done),
    .err           (err),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0]      v;
    logic [CNT_W-1:0] r;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_ret = 0;

  wire [10:0] obs = {fetch_unit_en, decoder_en, reg_r_en, alu_en, memory_r_en,
                     memory_w_en, reg_w_en, branch, branchi, done, err};

  task automatic push(input logic [10:0] v);
    exp_t e;
    e.v = v;
    e.r = CNT_W'(exp_ret);
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, nothing expected", tag);
      return;
    end
    e = sb.pop_front();
    assert ({obs, retired} === {e.v, e.r}) else begin
      errors++;
      $error("FAIL %s: observed flags=%b retired=%0d, expected flags=%b retired=%0d",
             tag, obs, retired, e.v, e.r);
    end
  endtask

  // Called at the negedge before the instruction's FETCH cycle.
  task automatic run_inst(input logic [2:0] t, input logic h, input string tag);
    int n;
    push(F);
    push(D);
    case (t)
      3'd1: begin push(N); push(R); push(A); push(W); end
      3'd2: push(h ? N : BI);
      3'd3: begin push(N); push(W); end
      3'd4: begin push(N); push(R | B); end
      3'd5: begin push(N); push(R); repeat (MEM_LAT) push(MW); end
      3'd6: begin push(N); push(R); repeat (MEM_LAT) push(MR); push(W); end
      default: push(N);
    endcase
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare(tag);
      if (i == 0) begin
        start     = 1'b0;
        inst_type = t;
        is_halt   = h;
      end
    end
    if (t inside {[3'd1:3'd6]}) exp_ret = (exp_ret == 15) ? 15 : exp_ret + 1;
  endtask

  task automatic halted(input int n, input logic [10:0] flags, input string tag);
    repeat (n) begin
      @(negedge clk);
      push(flags);
      compare(tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init      = 1'b1;
    start     = 1'b0;
    inst_type = 3'd0;
    is_halt   = 1'b0;
    @(negedge clk);
    push(N);
    compare("reset");
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    push(N);
    compare("idle");
    start     = 1'b1;
    inst_type = 3'd1;

    run_inst(3'd1, 1'b0, "alu");
    run_inst(3'd2, 1'b0, "immbr");
    run_inst(3'd4, 1'b0, "regbr");
    run_inst(3'd3, 1'b0, "mov");
    run_inst(3'd6, 1'b0, "ld");
    run_inst(3'd5, 1'b0, "st");
    run_inst(3'd7, 1'b0, "illegal");
    halted(3, DN | E, "illegal_halted");

    start = 1'b1;
    run_inst(3'd2, 1'b1, "halt");
    halted(10, DN, "halted");

    start = 1'b1;
    repeat (17) run_inst(3'd1, 1'b0, "alu_sat");

    @(posedge clk);
    #2 init = 1'b1;
    exp_ret = 0;
    #1 push(N);
    compare("init_async");
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    push(N);
    compare("idle_after_init");
    start = 1'b1;
    run_inst(3'd1, 1'b0, "alu_after_init");
    @(negedge clk);
    push(F);
    compare("fetch_after_init");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
